// File: rtl/sme_sched_pkg.sv
// sme_sched_pkg: shared tag record, release FSM states and default widths for the SME job scheduler
package sme_sched_pkg;
    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_ADDR_WIDTH     = 17;
    localparam int DEF_LEN_WIDTH      = 14;
    localparam int DEF_MAX_INFLIGHT   = 8;
    localparam int DEF_TIMEOUT_CYCLES = 65535;
    typedef struct packed {
        logic [7:0] req_id;
        logic [7:0] slot;
    } tag_t;
    typedef enum logic [1:0] {WAIT, REL, GAP} rel_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin request-to-one-hot grant; pointer moves past the winner when en is high
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);
    localparam int W = N > 1 ? $clog2(N) : 1;
    logic [W-1:0] ptr, gidx;
    logic found;
    int k;
    always_comb begin
        grant = '0;
        gidx  = ptr;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!found && req[k]) begin
                grant[k] = 1'b1;
                gidx     = W'(k);
                found    = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) ptr <= '0;
        else if (en && found) ptr <= gidx == W'(N-1) ? '0 : gidx + 1'b1;
    end
endmodule

// File: rtl/simple_fifo.sv
// simple_fifo: show-ahead synchronous FIFO, dout presents the head entry while not empty
module simple_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic do_push, do_pop;
    assign empty   = cnt == '0;
    assign full    = cnt == (AW+1)'(DEPTH);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;
    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp == AW'(DEPTH-1) ? '0 : wp + 1'b1;
            if (do_pop) rp <= rp == AW'(DEPTH-1) ? '0 : rp + 1'b1;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/sme_job_scheduler.sv
// sme_job_scheduler: credit-limited round-robin job issue to the SME and tagged in-order result return
// Optional watchdog with DMA stop enabled by defining SME_SCHED_TIMEOUT_EN.
module sme_job_scheduler
    import sme_sched_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH      = DEF_LEN_WIDTH,
    parameter int MAX_INFLIGHT   = DEF_MAX_INFLIGHT,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]      req_len,
    input  logic [NUM_REQ*8-1:0]              req_slot,
    input  logic [NUM_REQ*64-1:0]             req_preamble,
    input  logic [NUM_REQ*32-1:0]             req_ports,
    output logic                              cmd_valid,
    output logic [ADDR_WIDTH-1:0]             cmd_addr,
    output logic [LEN_WIDTH-1:0]              cmd_len,
    output logic [7:0]                        cmd_slot,
    output logic [63:0]                       cmd_preamble,
    output logic [31:0]                       cmd_ports,
    output logic                              cmd_stop,
    input  logic                              match_valid,
    input  logic                              match_last,
    input  logic [31:0]                       match_rule_id,
    output logic                              match_release,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [$clog2(NUM_REQ)-1:0]        res_req_id,
    output logic [7:0]                        res_slot,
    output logic [31:0]                       res_rule_id,
    output logic                              res_last,
    output logic                              res_timeout,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
    output logic                              err_timeout
);
    localparam int RW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_INFLIGHT+1);
    logic [CW-1:0] credits;
    logic [RW-1:0] gid;
    logic have_credit, issue, pop, rel_last, tag_empty, unused_full;
    logic [7:0] unused_id;
    tag_t tag_in, tag_head;
    rel_state_t state, state_n;
    assign have_credit = credits != '0;
    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (have_credit),
        .req   (have_credit ? req_valid : '0),
        .grant (req_ready)
    );
    assign issue = |req_ready;
    always_comb begin
        gid = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (req_ready[i]) gid = RW'(i);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid    <= 1'b0;
            cmd_addr     <= '0;
            cmd_len      <= '0;
            cmd_slot     <= '0;
            cmd_preamble <= '0;
            cmd_ports    <= '0;
        end else begin
            cmd_valid <= issue;
            if (issue) begin
                cmd_addr     <= req_addr[gid*ADDR_WIDTH +: ADDR_WIDTH];
                cmd_len      <= req_len[gid*LEN_WIDTH +: LEN_WIDTH];
                cmd_slot     <= req_slot[gid*8 +: 8];
                cmd_preamble <= req_preamble[gid*64 +: 64];
                cmd_ports    <= req_ports[gid*32 +: 32];
            end
        end
    end
    // tag is queued at accept so the credit is consumed before another grant can see it
    assign tag_in = '{req_id: 8'(gid), slot: req_slot[gid*8 +: 8]};
    simple_fifo #(.WIDTH($bits(tag_t)), .DEPTH(MAX_INFLIGHT)) u_tags (
        .clk   (clk),
        .rst   (rst),
        .push  (issue),
        .din   (tag_in),
        .pop   (pop),
        .dout  (tag_head),
        .empty (tag_empty),
        .full  (unused_full)
    );
    assign unused_id = tag_head.req_id;
    always_ff @(posedge clk) begin
        if (rst) credits <= CW'(MAX_INFLIGHT);
        else credits <= credits - CW'(issue) + CW'(pop);
    end
    assign inflight = CW'(MAX_INFLIGHT) - credits;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= WAIT;
            rel_last <= 1'b0;
        end else begin
            state <= state_n;
            if (state == WAIT && res_valid && res_ready) rel_last <= match_last;
        end
    end
    always_comb begin
        state_n = state == WAIT ? (res_valid && res_ready ? REL : WAIT) : state == REL ? GAP : WAIT;
    end
    assign res_valid     = state == WAIT && match_valid && !tag_empty;
    assign match_release = state == REL;
    assign pop           = match_release && rel_last;
    assign res_req_id    = res_valid ? tag_head.req_id[RW-1:0] : '0;
    assign res_slot      = res_valid ? tag_head.slot : '0;
    assign res_rule_id   = res_valid ? match_rule_id : '0;
    assign res_last      = res_valid && match_last;
`ifdef SME_SCHED_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wd;
    logic head_to, stop_q, err_q, count_en;
    assign count_en = state == WAIT && !tag_empty && !match_valid && !head_to;
    always_ff @(posedge clk) begin
        if (rst) begin
            wd      <= '0;
            head_to <= 1'b0;
            stop_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            stop_q <= 1'b0;
            if (state == REL || tag_empty) wd <= '0;
            else if (count_en) wd <= wd + 1'b1;
            if (count_en && wd == TO_LAST) begin
                stop_q  <= 1'b1;
                err_q   <= 1'b1;
                head_to <= 1'b1;
            end
            if (pop) head_to <= 1'b0;
        end
    end
    assign cmd_stop    = stop_q;
    assign err_timeout = err_q;
    assign res_timeout = res_valid && head_to;
`else
    logic unused_to;
    assign unused_to   = TIMEOUT_CYCLES != 0;
    assign cmd_stop    = 1'b0;
    assign err_timeout = 1'b0;
    assign res_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_sme_job_scheduler.sv
// tb_sme_job_scheduler: directed self-checking bench for sme_job_scheduler (watchdog checks follow SME_SCHED_TIMEOUT_EN)
module tb_sme_job_scheduler;
    localparam int N = 4, AW = 17, LW = 14, MI = 8;
`ifdef SME_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    logic clk = 1'b0, rst;
    logic [N-1:0] req_valid, req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*LW-1:0] req_len;
    logic [N*8-1:0] req_slot;
    logic [N*64-1:0] req_preamble;
    logic [N*32-1:0] req_ports;
    logic cmd_valid, cmd_stop, match_valid, match_last, match_release;
    logic res_valid, res_ready, res_last, res_timeout, err_timeout;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [7:0] cmd_slot, res_slot;
    logic [63:0] cmd_preamble;
    logic [31:0] cmd_ports, match_rule_id, res_rule_id;
    logic [1:0] res_req_id;
    logic [3:0] inflight;
    int n_checks = 0, n_fail = 0;
    always #5 clk = ~clk;
    sme_job_scheduler #(.NUM_REQ(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .MAX_INFLIGHT(MI), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len), .req_slot(req_slot),
        .req_preamble(req_preamble), .req_ports(req_ports),
        .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_slot(cmd_slot),
        .cmd_preamble(cmd_preamble), .cmd_ports(cmd_ports), .cmd_stop(cmd_stop),
        .match_valid(match_valid), .match_last(match_last), .match_rule_id(match_rule_id),
        .match_release(match_release), .res_valid(res_valid), .res_ready(res_ready),
        .res_req_id(res_req_id), .res_slot(res_slot), .res_rule_id(res_rule_id),
        .res_last(res_last), .res_timeout(res_timeout), .inflight(inflight), .err_timeout(err_timeout)
    );
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step;
        @(negedge clk);
    endtask
    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l, input logic [7:0] s);
        req_addr[i*AW +: AW]     = a;
        req_len[i*LW +: LW]      = l;
        req_slot[i*8 +: 8]       = s;
        req_preamble[i*64 +: 64] = 64'hCAFE_0000_0000_0000 | 64'(i);
        req_ports[i*32 +: 32]    = {16'(1000 + i), 16'd80};
    endtask
    logic [3:0] rr_exp [6] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    logic [7:0] rr_slot [6] = '{8'h10, 8'h11, 8'h13, 8'h10, 8'h11, 8'h13};
    int cnt, at;
    initial begin
        rst = 1'b1; req_valid = '0; match_valid = 1'b0; match_last = 1'b0; match_rule_id = '0; res_ready = 1'b0;
        set_req(0, 17'h040, 14'd10, 8'h10);
        set_req(1, 17'h080, 14'd20, 8'h11);
        set_req(2, 17'h100, 14'd64, 8'h05);
        set_req(3, 17'h180, 14'd30, 8'h13);
        step; step;
        chk("rst_req_ready", req_ready, 0); chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_inflight", inflight, 0); chk("rst_res_valid", res_valid, 0);
        chk("rst_release", match_release, 0); chk("rst_stop", cmd_stop, 0); chk("rst_err", err_timeout, 0);
        rst = 1'b0;
        // single job from requester 2
        req_valid = 4'b0100; #1;
        chk("t1_grant", req_ready, 4'b0100);
        step; req_valid = '0;
        chk("t1_cmd_valid", cmd_valid, 1); chk("t1_cmd_addr", cmd_addr, 'h100);
        chk("t1_cmd_len", cmd_len, 64); chk("t1_cmd_slot", cmd_slot, 5);
        chk("t1_cmd_pre", cmd_preamble, 64'hCAFE_0000_0000_0002);
        chk("t1_cmd_ports", cmd_ports, {16'd1002, 16'd80}); chk("t1_inflight1", inflight, 1);
        step;
        chk("t1_cmd_pulse", cmd_valid, 0); chk("t1_cmd_hold", cmd_addr, 'h100);
        match_valid = 1'b1; match_last = 1'b1; match_rule_id = 32'h1234; res_ready = 1'b1; #1;
        chk("t1_res_valid", res_valid, 1); chk("t1_res_id", res_req_id, 2); chk("t1_res_slot", res_slot, 5);
        chk("t1_res_rule", res_rule_id, 32'h1234); chk("t1_res_last", res_last, 1); chk("t1_res_to", res_timeout, 0);
        step; match_valid = 1'b0;
        chk("t1_release", match_release, 1); chk("t1_res_gap", res_valid, 0); chk("t1_inflight_rel", inflight, 1);
        step;
        chk("t1_release_once", match_release, 0); chk("t1_inflight0", inflight, 0);
        step;
        chk("t1_release_idle", match_release, 0);
        // round robin over requesters 0,1,3 from a fresh pointer
        rst = 1'b1; step; rst = 1'b0;
        req_valid = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t2_grant", req_ready, rr_exp[k]);
            if (k > 0) chk("t2_cmd_slot", cmd_slot, rr_slot[k-1]);
            step;
        end
        req_valid = '0;
        chk("t2_last_cmd", cmd_valid, 1); chk("t2_last_slot", cmd_slot, 8'h13); chk("t2_inflight", inflight, 6);
        // reset with jobs in flight and a match pending
        match_valid = 1'b1; res_ready = 1'b0; rst = 1'b1;
        step;
        chk("t3_inflight", inflight, 0); chk("t3_res_valid", res_valid, 0);
        chk("t3_cmd_valid", cmd_valid, 0); chk("t3_release", match_release, 0);
        rst = 1'b0; match_valid = 1'b0; req_valid = 4'b1111; #1;
        chk("t3_ptr_reset", req_ready, 4'b0001);
        // credit exhaustion with all requesters asking continuously
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step;
            if (cmd_valid) cnt++;
        end
        chk("t4_issues", cnt, 8); chk("t4_no_ready", req_ready, 0);
        chk("t4_inflight", inflight, 8); chk("t4_last_slot", cmd_slot, 8'h13);
        match_valid = 1'b1; match_last = 1'b1; match_rule_id = 32'h55; res_ready = 1'b1; #1;
        chk("t4_res_id", res_req_id, 0); chk("t4_res_slot", res_slot, 8'h10);
        step; match_valid = 1'b0;
        chk("t4_release", match_release, 1);
        step;
        chk("t4_inflight7", inflight, 7); chk("t4_regrant", req_ready, 4'b0001);
        step;
        chk("t4_one_more", cmd_valid, 1); chk("t4_one_slot", cmd_slot, 8'h10);
        chk("t4_inflight8", inflight, 8); chk("t4_blocked", req_ready, 0);
        cnt = 0;
        repeat (5) begin
            step;
            if (cmd_valid) cnt++;
        end
        chk("t4_no_extra", cnt, 0);
        req_valid = '0;
        // three matches on the head job (requester 1), first one stalled
        match_valid = 1'b1; match_last = 1'b0; match_rule_id = 32'hA1; res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t5_stall_valid", res_valid, 1); chk("t5_stall_rule", res_rule_id, 32'hA1);
            chk("t5_stall_id", res_req_id, 1); chk("t5_stall_slot", res_slot, 8'h11);
            chk("t5_stall_last", res_last, 0); chk("t5_stall_rel", match_release, 0);
            step;
        end
        res_ready = 1'b1;
        step; match_rule_id = 32'hA2;
        chk("t5_rel1", match_release, 1);
        step;
        chk("t5_gap1_rel", match_release, 0); chk("t5_gap1_res", res_valid, 0);
        step;
        chk("t5_res2", res_valid, 1); chk("t5_rule2", res_rule_id, 32'hA2);
        step; match_last = 1'b1; match_rule_id = 32'hA3;
        chk("t5_rel2", match_release, 1);
        step;
        chk("t5_no_pop2", inflight, 8);
        step;
        chk("t5_res3", res_valid, 1); chk("t5_rule3", res_rule_id, 32'hA3); chk("t5_last3", res_last, 1);
        step; match_valid = 1'b0; match_last = 1'b0;
        chk("t5_rel3", match_release, 1); chk("t5_pre_pop", inflight, 8);
        step;
        chk("t5_pop3", inflight, 7); chk("t5_rel3_once", match_release, 0);
        // match with no outstanding job is ignored
        rst = 1'b1; step; rst = 1'b0;
        match_valid = 1'b1; #1;
        chk("t6_res_valid", res_valid, 0);
        step; step;
        chk("t6_release", match_release, 0);
        match_valid = 1'b0;
        // job that never sees a match
        req_valid = 4'b0100;
        step; req_valid = '0;
        chk("t7_cmd", cmd_valid, 1);
        cnt = 0; at = 0;
        for (int i = 1; i <= 150; i++) begin
            step;
            if (cmd_stop) begin
                cnt++;
                at = i;
            end
        end
        chk("t7_stop_pulses", cnt, TO_EN ? 1 : 0); chk("t7_stop_cycle", at, TO_EN ? 100 : 0);
        chk("t7_err", err_timeout, TO_EN);
        match_valid = 1'b1; match_last = 1'b1; match_rule_id = 32'h77; res_ready = 1'b1; #1;
        chk("t7_res_valid", res_valid, 1); chk("t7_res_to", res_timeout, TO_EN);
        step; match_valid = 1'b0;
        chk("t7_release", match_release, 1);
        step;
        chk("t7_inflight", inflight, 0); chk("t7_err_sticky", err_timeout, TO_EN);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
